// File: rtl/mips_mem_pkg.sv
// Shared types for the MIPS32 bench memory model: port FSM states, word/address
// types, the latched request record and the byte-lane merge used on writes.
package mips_mem_pkg;

  typedef logic [31:0] word_t;
  typedef logic [29:0] waddr_t;

  localparam int BYTE_LANES = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } port_state_t;

  typedef struct packed {
    logic                  rd;
    logic [BYTE_LANES-1:0] we;
    word_t                 wdata;
  } mem_req_t;

  function automatic word_t merge_bytes(input word_t old_w, input word_t new_w,
                                        input logic [BYTE_LANES-1:0] we);
    word_t res;
    res = old_w;
    for (int b = 0; b < BYTE_LANES; b++) begin
      if (we[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mips_mem_port.sv
// One memory port: accepts a request in IDLE, counts down the wait states
// (frozen by stall), then holds DONE for exactly one cycle.
module mips_mem_port
  import mips_mem_pkg::*;
#(
  parameter int     LATENCY     = 1,
  parameter int     DEPTH_WORDS = 4096,
  parameter waddr_t BASE_WORD   = '0,
  parameter int     IDX_W       = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic                  i_rd,
  input  logic [BYTE_LANES-1:0] i_we,
  input  waddr_t                i_addr,
  input  word_t                 i_wdata,
  input  logic                  i_stall,
  output logic                  o_done,
  output logic                  o_oor_accept,
  output logic                  o_in_range,
  output logic [IDX_W-1:0]      o_idx,
  output mem_req_t              o_req
);

  localparam int               CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  port_state_t      r_state;
  port_state_t      w_state_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             w_accept;
  waddr_t           w_idx_full;
  logic             w_in_range;

  logic             r_in_range;
  logic [IDX_W-1:0] r_idx;
  mem_req_t         r_req;

  // Addresses below BASE_WORD wrap to large indices and fall out of range.
  assign w_idx_full = i_addr - BASE_WORD;
  assign w_in_range = ({2'b00, w_idx_full} < 32'(DEPTH_WORDS));

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_accept   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_req) begin
          w_accept   = 1'b1;
          w_cnt_nx   = CNT_LOAD;
          w_state_nx = (LATENCY == 1) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (!i_stall) begin
          w_cnt_nx = r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) w_state_nx = DONE;
        end
      end
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // Request capture; only these latched values are used after acceptance.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_in_range <= w_in_range;
      r_idx      <= w_idx_full[IDX_W-1:0];
      r_req.rd   <= i_rd;
      r_req.we   <= i_we;
      r_req.wdata <= i_wdata;
    end
  end

  assign o_done       = (r_state == DONE);
  assign o_oor_accept = w_accept && !w_in_range;
  assign o_in_range   = r_in_range;
  assign o_idx        = r_idx;
  assign o_req        = r_req;

endmodule

// File: rtl/mips_mem_model.sv
// Dual-port (instruction + data) memory model over one shared word array with
// per-port wait states, stall injection, out-of-range flag and access counter.
module mips_mem_model
  import mips_mem_pkg::*;
#(
  parameter int     DEPTH_WORDS  = 4096,
  parameter waddr_t BASE_WORD    = 30'h0,
  parameter int     INST_LATENCY = 1,
  parameter int     DATA_LATENCY = 2,
  parameter string  INIT_FILE    = ""
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        InstMem_Read,
  input  logic [29:0] InstMem_Address,
  output logic [31:0] InstMem_In,
  output logic        InstMem_Ready,
  input  logic        DataMem_Read,
  input  logic [3:0]  DataMem_Write,
  input  logic [29:0] DataMem_Address,
  input  logic [31:0] DataMem_Out,
  output logic [31:0] DataMem_In,
  output logic        DataMem_Ready,
  input  logic        InstStall,
  input  logic        DataStall,
  output logic        OutOfRange,
  output logic [31:0] AccessCount
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  word_t r_mem [DEPTH_WORDS];

  logic             w_inst_done, w_inst_oor, w_inst_in_range;
  logic [IDX_W-1:0] w_inst_idx;
  mem_req_t         w_inst_req;
  logic             w_data_done, w_data_oor, w_data_in_range;
  logic [IDX_W-1:0] w_data_idx;
  mem_req_t         w_data_req;
  logic             r_oor;
  logic [31:0]      r_access_cnt;

  mips_mem_port #(
    .LATENCY    (INST_LATENCY),
    .DEPTH_WORDS(DEPTH_WORDS),
    .BASE_WORD  (BASE_WORD),
    .IDX_W      (IDX_W)
  ) u_inst_port (
    .clock       (clock),
    .reset       (reset),
    .i_req       (InstMem_Read),
    .i_rd        (1'b1),
    .i_we        ('0),
    .i_addr      (InstMem_Address),
    .i_wdata     ('0),
    .i_stall     (InstStall),
    .o_done      (w_inst_done),
    .o_oor_accept(w_inst_oor),
    .o_in_range  (w_inst_in_range),
    .o_idx       (w_inst_idx),
    .o_req       (w_inst_req)
  );

  mips_mem_port #(
    .LATENCY    (DATA_LATENCY),
    .DEPTH_WORDS(DEPTH_WORDS),
    .BASE_WORD  (BASE_WORD),
    .IDX_W      (IDX_W)
  ) u_data_port (
    .clock       (clock),
    .reset       (reset),
    .i_req       (DataMem_Read || (|DataMem_Write)),
    .i_rd        (DataMem_Read),
    .i_we        (DataMem_Write),
    .i_addr      (DataMem_Address),
    .i_wdata     (DataMem_Out),
    .i_stall     (DataStall),
    .o_done      (w_data_done),
    .o_oor_accept(w_data_oor),
    .o_in_range  (w_data_in_range),
    .o_idx       (w_data_idx),
    .o_req       (w_data_req)
  );

  // Reads see the array before this cycle's write, so a read-modify request and
  // a same-cycle instruction fetch both return the pre-write word.
  assign InstMem_In    = (w_inst_done && w_inst_req.rd && w_inst_in_range) ? r_mem[w_inst_idx] : '0;
  assign DataMem_In    = (w_data_done && w_data_req.rd && w_data_in_range) ? r_mem[w_data_idx] : '0;
  assign InstMem_Ready = w_inst_done;
  assign DataMem_Ready = w_data_done;
  assign OutOfRange    = r_oor;
  assign AccessCount   = r_access_cnt;

  always_ff @(posedge clock) begin
    if (!reset && w_data_done && w_data_in_range && (|w_data_req.we)) begin
      r_mem[w_data_idx] <= merge_bytes(r_mem[w_data_idx], w_data_req.wdata, w_data_req.we);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_oor        <= 1'b0;
      r_access_cnt <= '0;
    end else begin
      if (w_inst_oor || w_data_oor) r_oor <= 1'b1;
      r_access_cnt <= r_access_cnt + 32'(w_inst_done) + 32'(w_data_done);
    end
  end

endmodule
